instr_mem_server: RTL and testbench
===================================

# instr_mem_server

Instruction-side responder for `top_datapath`. It holds the program image, accepts a sequential program load through a valid/ready port, and in run mode returns the instruction word for the core's current PC one clock after each edge. It also detects the all-zero halt word and flags fetches that fall outside the memory.

## Interface
- `N`, 16, instruction and PC width.
- `DEPTH`, 64, number of instruction words; must be a power of two, at least 2.
- `AW`, 6, address bits; must equal log2(`DEPTH`).

Ports (the only reset is `Reset`):
- `Clock`  in  1  sole clock; all state updates on its rising edge.
- `Reset`  in  1  asynchronous, active-low; clears all state except memory contents.
- `Load_valid`  in  1  `Load_data` holds a program word.
- `Load_data`  in  N  program word, written at the next sequential address.
- `Load_last`  in  1  qualifies the current handshake cycle as the final word.
- `Load_ready`  out  1  block accepts a word this cycle.
- `Load_count`  out  AW+1  number of words written since the last load started.
- `Start`  in  1  one-cycle pulse; begins a load or a run (see Operation).
- `Start_load`  in  1  with `Start`, selects load instead of run.
- `PC_in`  in  N  core program counter.
- `Instruction`  out  N  fetched word.
- `Instr_valid`  out  1  `Instruction` is a valid fetch.
- `Halted`  out  1  halt word fetched.
- `Fault`  out  1  sticky error flag.

## Operation
States: IDLE, LOAD, RUN, HALT. Reset enters IDLE.

**IDLE**
- `Start & Start_load` → LOAD, and `Load_count` is cleared to 0.
- `Start & !Start_load` → RUN.

**LOAD**
- `Load_ready = (Load_count < DEPTH)`.
- Accept when `Load_valid & Load_ready`: `mem[Load_count] <= Load_data`, `Load_count` increments.
- Exit on `Load_valid & Load_last` → IDLE, whether or not the word is accepted.
- When `Load_count == DEPTH`, `Load_ready` stays 0. Further words are dropped and `Fault` is set on each dropped `Load_valid`.
- `Start` is ignored while in LOAD.

**RUN**
- Every cycle: `Instruction <= mem[PC_in[AW-1:0]]` and `Instr_valid <= 1`.
- If `PC_in >= DEPTH`: `Instruction <= 0`, `Fault <= 1`, `Instr_valid <= 1`.
- Halt: when `Instr_valid` is 1 and `Instruction == 0`, go to HALT on the next edge, clear `Instr_valid`, and set `Halted`.
- An out-of-range fetch returns 0, so it also halts.

**HALT**
- Hold `Instruction`; `Instr_valid = 0`.
- `Start & !Start_load` → RUN and clears `Halted`.
- `Start & Start_load` → LOAD and clears `Halted`.

**General**
- `Fault` is sticky. Only `Reset` clears it.
- Words in memory at addresses at or above `Load_count` keep their previous contents.

## Timing
- Reset values: `Load_ready = 0`, `Load_count = 0`, `Instruction = 0`, `Instr_valid = 0`, `Halted = 0`, `Fault = 0`, state IDLE.
- `Reset` asserted mid-load or mid-run aborts immediately. Words already written remain in memory.
- Load throughput is one word per clock.
- `Load_ready` is a registered function of state and `Load_count`. It rises the cycle after the `Start` edge.
- Fetch latency is 1 clock: `PC_in` sampled at edge k appears on `Instruction` after edge k.
- The first valid fetch is visible after the first edge spent in RUN. That is 2 edges after `Start` is sampled.
- The halt word is visible for exactly one cycle with `Instr_valid = 1`. `Halted` rises on the following edge.
- Same-cycle `Load_valid & Load_last` with `Load_ready`: the word is written and the state goes to IDLE on that edge.

## Configuration
- `IMEM_PARITY_EN` defined:
  - Each word stores an extra even-parity bit computed at load.
  - Each fetch checks it. On mismatch: `Fault <= 1`, `Instruction <= 0`, so the halt path is taken.
- Not defined: no parity storage or check. Memory width is N.

## Test plan
- **Load:** after reset, pulse `Start` with `Start_load = 1`; load 0x8041, 0x8082, 0x80C3, then 0x0000 with `Load_last`. Expect `Load_count = 4` and return to IDLE.
- **Run:** pulse `Start` with `Start_load = 0`, then drive `PC_in` = 0,1,2,3 on consecutive edges.
  - Expect `Instruction` = 0x8041, 0x8082, 0x80C3, 0x0000, each one cycle later.
  - `Halted` = 1 the cycle after 0x0000 appears; `Instr_valid` = 0 from then on.
- **Out of range:** with `DEPTH = 64`, drive `PC_in = 64` in RUN. Expect `Instruction = 0`, `Fault = 1`, then `Halted = 1`.
- **Overflow:** load 65 words with `Load_valid` held high. `Load_ready` drops after 64 words, the 65th word is dropped, `Fault = 1`, `Load_count = 64`.
- **Reset mid-run:** assert `Reset` low in the middle of a RUN cycle.
  - All outputs go to 0 immediately.
  - A following run returns the same words as before reset, because memory contents are retained.
- **Parity (`IMEM_PARITY_EN` defined):** load 0x8041, force-flip one stored bit, fetch address 0. Expect `Instruction = 0`, `Fault = 1`, `Halted = 1`.

Source files
------------

// File: rtl/instr_mem_server.sv
// Instruction memory responder: sequential valid/ready program load, one-cycle fetch in run mode,
// halt-word detection and a sticky fault flag. Optional stored even parity under `IMEM_PARITY_EN`.
module instr_mem_server #(
  parameter int N     = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Load_valid,
  input  logic [N-1:0]  Load_data,
  input  logic          Load_last,
  output logic          Load_ready,
  output logic [AW:0]   Load_count,
  input  logic          Start,
  input  logic          Start_load,
  input  logic [N-1:0]  PC_in,
  output logic [N-1:0]  Instruction,
  output logic          Instr_valid,
  output logic          Halted,
  output logic          Fault
);

`ifdef IMEM_PARITY_EN
  localparam int MW = N + 1;
`else
  localparam int MW = N;
`endif
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

  logic [MW-1:0] r_mem [DEPTH];
  state_t        r_state;
  logic          r_load_ready;
  logic [AW:0]   r_load_count;
  logic [N-1:0]  r_instruction;
  logic          r_instr_valid;
  logic          r_halted;
  logic          r_fault;

  logic          w_accept;
  logic          w_drop;
  logic [AW:0]   w_count_inc;
  logic          w_pc_oob;
  logic [MW-1:0] w_rd_word;
  logic [MW-1:0] w_wr_word;
  logic [N-1:0]  w_fetch_data;
  logic          w_fetch_bad;
  logic          w_halt_seen;

  assign w_accept    = (r_state == S_LOAD) & Load_valid & r_load_ready;
  assign w_drop      = (r_state == S_LOAD) & Load_valid & ~r_load_ready;
  assign w_count_inc = r_load_count + 1'b1;
  assign w_pc_oob    = |PC_in[N-1:AW];
  assign w_rd_word   = r_mem[PC_in[AW-1:0]];
  assign w_halt_seen = r_instr_valid & (r_instruction == '0);

`ifdef IMEM_PARITY_EN
  // Parity bit sits above the data so the whole stored word XORs to zero when intact.
  assign w_wr_word    = {^Load_data, Load_data};
  assign w_fetch_data = w_rd_word[N-1:0];
  assign w_fetch_bad  = w_pc_oob | (^w_rd_word);
`else
  assign w_wr_word    = Load_data;
  assign w_fetch_data = w_rd_word;
  assign w_fetch_bad  = w_pc_oob;
`endif

  // Memory has no reset so a program survives Reset.
  always_ff @(posedge Clock) begin
    if (w_accept) begin
      r_mem[r_load_count[AW-1:0]] <= w_wr_word;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state       <= S_IDLE;
      r_load_ready  <= 1'b0;
      r_load_count  <= '0;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (Start_load) begin
              r_state      <= S_LOAD;
              r_load_count <= '0;
              r_load_ready <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_LOAD: begin
          if (w_accept) r_load_count <= w_count_inc;
          if (w_drop)   r_fault      <= 1'b1;
          // A last-flagged word ends the load even when it is dropped.
          if (Load_valid & Load_last) begin
            r_state      <= S_IDLE;
            r_load_ready <= 1'b0;
          end else if (w_accept) begin
            r_load_ready <= (w_count_inc < C_DEPTH);
          end
        end
        S_RUN: begin
          if (w_halt_seen) begin
            r_state       <= S_HALT;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b1;
          end else begin
            r_instr_valid <= 1'b1;
            if (w_fetch_bad) begin
              r_instruction <= '0;
              r_fault       <= 1'b1;
            end else begin
              r_instruction <= w_fetch_data;
            end
          end
        end
        S_HALT: begin
          if (Start) begin
            r_halted <= 1'b0;
            if (Start_load) begin
              r_state      <= S_LOAD;
              r_load_count <= '0;
              r_load_ready <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Load_ready  = r_load_ready;
  assign Load_count  = r_load_count;
  assign Instruction = r_instruction;
  assign Instr_valid = r_instr_valid;
  assign Halted      = r_halted;
  assign Fault       = r_fault;

endmodule

// File: tb/tb_instr_mem_server.sv
// Directed-vector bench for instr_mem_server: load, run/halt, out-of-range, reset mid-run,
// overflow and (with IMEM_PARITY_EN) a corrupted stored word.
module tb_instr_mem_server;
  localparam int N = 16, DEPTH = 64, AW = 6;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Load_valid;
  logic [N-1:0]  Load_data;
  logic          Load_last;
  logic          Load_ready;
  logic [AW:0]   Load_count;
  logic          Start;
  logic          Start_load;
  logic [N-1:0]  PC_in;
  logic [N-1:0]  Instruction;
  logic          Instr_valid;
  logic          Halted;
  logic          Fault;

  int n_vec  = 0;
  int n_miss = 0;

  instr_mem_server #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset),
    .Load_valid(Load_valid), .Load_data(Load_data), .Load_last(Load_last),
    .Load_ready(Load_ready), .Load_count(Load_count),
    .Start(Start), .Start_load(Start_load), .PC_in(PC_in),
    .Instruction(Instruction), .Instr_valid(Instr_valid),
    .Halted(Halted), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one rising edge, then settle 1ns so registered outputs are stable.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_start(input logic ld);
    Start = 1'b1; Start_load = ld;
    tick();
    Start = 1'b0; Start_load = 1'b0;
  endtask

  task automatic fetch(input logic [N-1:0] pc);
    PC_in = pc;
    tick();
  endtask

  logic [N-1:0] prog [4];

  initial begin
    prog[0] = 16'h8041; prog[1] = 16'h8082; prog[2] = 16'h80C3; prog[3] = 16'h0000;
    Reset = 1'b0; Load_valid = 1'b0; Load_data = '0; Load_last = 1'b0;
    Start = 1'b0; Start_load = 1'b0; PC_in = '0;
    #12;
    chk("rst_ready", 32'(Load_ready), 32'd0);
    chk("rst_count", 32'(Load_count), 32'd0);
    chk("rst_instr", 32'(Instruction), 32'd0);
    chk("rst_valid", 32'(Instr_valid), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_fault", 32'(Fault), 32'd0);
    Reset = 1'b1;
    tick();

    // Load four words, the last carrying Load_last.
    pulse_start(1'b1);
    chk("load_ready_up", 32'(Load_ready), 32'd1);
    chk("load_count0", 32'(Load_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      Load_valid = 1'b1; Load_data = prog[i]; Load_last = (i == 3);
      tick();
    end
    Load_valid = 1'b0; Load_last = 1'b0;
    chk("load_count4", 32'(Load_count), 32'd4);
    chk("load_ready_dn", 32'(Load_ready), 32'd0);

    // Run: first fetch lands two edges after Start.
    PC_in = '0;
    pulse_start(1'b0);
    chk("run_first_valid", 32'(Instr_valid), 32'd0);
    fetch(16'd0); chk("run_pc0", 32'(Instruction), 32'h8041); chk("run_v0", 32'(Instr_valid), 32'd1);
    fetch(16'd1); chk("run_pc1", 32'(Instruction), 32'h8082);
    fetch(16'd2); chk("run_pc2", 32'(Instruction), 32'h80C3);
    fetch(16'd3); chk("run_pc3", 32'(Instruction), 32'h0000);
    chk("run_v3", 32'(Instr_valid), 32'd1);
    chk("run_nohalt_yet", 32'(Halted), 32'd0);
    fetch(16'd0);
    chk("halt_up", 32'(Halted), 32'd1);
    chk("halt_valid", 32'(Instr_valid), 32'd0);
    fetch(16'd1);
    chk("halt_hold", 32'(Halted), 32'd1);
    chk("halt_hold_valid", 32'(Instr_valid), 32'd0);
    chk("no_fault", 32'(Fault), 32'd0);

    // Restart from HALT, then reset in mid-cycle.
    PC_in = 16'd1;
    pulse_start(1'b0);
    chk("restart_halted_clr", 32'(Halted), 32'd0);
    fetch(16'd1); chk("rerun_pc1", 32'(Instruction), 32'h8082);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_instr", 32'(Instruction), 32'd0);
    chk("midrst_valid", 32'(Instr_valid), 32'd0);
    #1 Reset = 1'b1;
    pulse_start(1'b0);
    fetch(16'd2); chk("post_rst_pc2", 32'(Instruction), 32'h80C3);
    fetch(16'd0); chk("post_rst_pc0", 32'(Instruction), 32'h8041);

    // Out-of-range fetch returns 0, faults, then halts.
    fetch(16'd64);
    chk("oob_instr", 32'(Instruction), 32'd0);
    chk("oob_valid", 32'(Instr_valid), 32'd1);
    chk("oob_fault", 32'(Fault), 32'd1);
    fetch(16'd0);
    chk("oob_halted", 32'(Halted), 32'd1);

    // Clear the sticky fault, then overflow the memory.
    Reset = 1'b0; #2 Reset = 1'b1;
    chk("fault_clr", 32'(Fault), 32'd0);
    pulse_start(1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      Load_valid = 1'b1; Load_data = 16'h1000 + 16'(i); Load_last = 1'b0;
      tick();
      if (i == DEPTH - 2) chk("ovf_ready_63", 32'(Load_ready), 32'd1);
    end
    chk("ovf_count64", 32'(Load_count), 32'd64);
    chk("ovf_ready_dn", 32'(Load_ready), 32'd0);
    chk("ovf_nofault", 32'(Fault), 32'd0);
    Load_data = 16'hBEEF; Load_last = 1'b1;
    tick();
    Load_valid = 1'b0; Load_last = 1'b0;
    chk("ovf_fault", 32'(Fault), 32'd1);
    chk("ovf_count_hold", 32'(Load_count), 32'd64);
    pulse_start(1'b0);
    fetch(16'd0);  chk("ovf_mem0", 32'(Instruction), 32'h1000);
    fetch(16'd63); chk("ovf_mem63", 32'(Instruction), 32'h103F);

`ifdef IMEM_PARITY_EN
    Reset = 1'b0; #2 Reset = 1'b1;
    pulse_start(1'b1);
    Load_valid = 1'b1; Load_data = 16'h8041; Load_last = 1'b1;
    tick();
    Load_valid = 1'b0; Load_last = 1'b0;
    dut.r_mem[0] = dut.r_mem[0] ^ 17'h00001;
    pulse_start(1'b0);
    fetch(16'd0);
    chk("par_instr", 32'(Instruction), 32'd0);
    chk("par_fault", 32'(Fault), 32'd1);
    fetch(16'd0);
    chk("par_halted", 32'(Halted), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
